// File: rtl/fsm_pkg.sv
// Shared definitions for the Moore-FSM observation logic: state encoding and
// default run-length counter width.
package fsm_pkg;

  localparam logic SYNC = 1'b0;
  localparam logic RUN  = 1'b1;

  localparam int unsigned CW_DEF = 8;

endpackage : fsm_pkg

// File: rtl/sat_counter.sv
// Run-length counter: loads 1 on clr, otherwise counts up on inc and holds at
// the all-ones value instead of wrapping.
module sat_counter #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          max
);

  localparam logic [CW-1:0] MAX_VAL = '1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= CW'(1);
    end else if (inc && !max) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign max = (cnt == MAX_VAL);

endmodule : sat_counter

// File: rtl/y_run_meter.sv
// Measures each maximal run of constant y and offers {level, length, saturated}
// on a one-deep valid/ready output register; results that cannot be held are dropped.
module y_run_meter
  import fsm_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          y,
  output logic          run_vld,
  input  logic          run_rdy,
  output logic          run_lvl,
  output logic [CW-1:0] run_len,
  output logic          run_sat,
  output logic          ovf
);

  logic          r_state;
  logic          r_lvl;
  logic [CW-1:0] w_cnt;
  logic          w_max;
  logic          w_end;
  logic          w_xfer;
  logic          w_clr;
  logic          w_inc;

  // A run ends on the first edge that samples a level different from the run's.
  assign w_end  = (r_state == RUN) && (y != r_lvl);
  assign w_xfer = run_vld && run_rdy;
  assign w_clr  = (r_state == SYNC) || w_end;
  assign w_inc  = (r_state == RUN) && !w_end;

  sat_counter #(.CW(CW)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .inc (w_inc),
    .cnt (w_cnt),
    .max (w_max)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= SYNC;
      r_lvl   <= 1'b0;
      run_vld <= 1'b0;
      run_lvl <= 1'b0;
      run_len <= '0;
      run_sat <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        SYNC: begin
          r_state <= RUN;
          r_lvl   <= y;
        end
        default: begin
          if (w_end) begin
            r_lvl <= y;
          end
        end
      endcase

      // Output register: a slot freed by this edge's transfer may be refilled at once.
      if (w_end) begin
        if (!run_vld || w_xfer) begin
          run_vld <= 1'b1;
          run_lvl <= r_lvl;
          run_len <= w_cnt;
          run_sat <= w_max;
        end else begin
          ovf <= 1'b1;
        end
      end else if (w_xfer) begin
        run_vld <= 1'b0;
      end
    end
  end

endmodule : y_run_meter

// File: tb/tb_y_run_meter.sv
// Directed self-checking bench for y_run_meter with CW=8; expected tuples are
// hand-derived from the run-length behaviour.
module tb_y_run_meter;

  localparam int unsigned CW = 8;

  logic          clk;
  logic          rst;
  logic          y;
  logic          run_vld;
  logic          run_rdy;
  logic          run_lvl;
  logic [CW-1:0] run_len;
  logic          run_sat;
  logic          ovf;

  int errors;
  int checks;

  // {vld, lvl, len, sat, ovf}
  logic [11:0] obs;
  assign obs = {run_vld, run_lvl, run_len, run_sat, ovf};

  y_run_meter #(.CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .y       (y),
    .run_vld (run_vld),
    .run_rdy (run_rdy),
    .run_lvl (run_lvl),
    .run_len (run_len),
    .run_sat (run_sat),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present y for the next edge, then sample 1 time unit after that edge.
  task automatic cyc(input logic yv);
    y = yv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(1'b0);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    run_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(i[0]);
      checks++;
      if (obs !== 12'h000) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%h want=%h", i, obs, 12'h000);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_basic_run();
    int vld_seen;
    do_reset();
    run_rdy  = 1'b1;
    vld_seen = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0);
      if (run_vld) vld_seen++;
    end
    checks++;
    if (vld_seen != 0) begin
      errors++;
      $display("FAIL basic_no_early_vld got=%0d want=0", vld_seen);
    end
    cyc(1'b1);
    checks++;
    if (obs !== {1'b1, 1'b0, 8'd5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_result got=%h want=%h", obs, {1'b1, 1'b0, 8'd5, 1'b0, 1'b0});
    end
    cyc(1'b1);
    checks++;
    if (run_vld !== 1'b0) begin
      errors++;
      $display("FAIL basic_vld_one_cycle got=%b want=0", run_vld);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    run_rdy = 1'b1;
    for (int i = 0; i < 300; i++) cyc(1'b1);
    cyc(1'b0);
    checks++;
    if (obs !== {1'b1, 1'b1, 8'd255, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sat_300 got=%h want=%h", obs, {1'b1, 1'b1, 8'd255, 1'b1, 1'b0});
    end
    // Run of 254 cycles: one short of saturation.
    for (int i = 0; i < 253; i++) cyc(1'b0);
    cyc(1'b1);
    checks++;
    if (obs !== {1'b1, 1'b0, 8'd254, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sat_254 got=%h want=%h", obs, {1'b1, 1'b0, 8'd254, 1'b0, 1'b0});
    end
    // Run of exactly 255 cycles.
    for (int i = 0; i < 254; i++) cyc(1'b1);
    cyc(1'b0);
    checks++;
    if (obs !== {1'b1, 1'b1, 8'd255, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sat_255 got=%h want=%h", obs, {1'b1, 1'b1, 8'd255, 1'b1, 1'b0});
    end
  endtask

  task automatic test_overflow();
    do_reset();
    run_rdy = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
    checks++;
    if (obs !== {1'b1, 1'b0, 8'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ovf_first_held got=%h want=%h", obs, {1'b1, 1'b0, 8'd2, 1'b0, 1'b0});
    end
    cyc(1'b0);
    checks++;
    if (obs !== {1'b1, 1'b0, 8'd2, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ovf_drop1 got=%h want=%h", obs, {1'b1, 1'b0, 8'd2, 1'b0, 1'b1});
    end
    cyc(1'b1);
    checks++;
    if (obs !== {1'b1, 1'b0, 8'd2, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ovf_drop2 got=%h want=%h", obs, {1'b1, 1'b0, 8'd2, 1'b0, 1'b1});
    end
    run_rdy = 1'b1;
    cyc(1'b1);
    run_rdy = 1'b0;
    checks++;
    if ({run_vld, ovf} !== 2'b01) begin
      errors++;
      $display("FAIL ovf_drain got vld/ovf=%b want=01", {run_vld, ovf});
    end
    cyc(1'b1);
    checks++;
    if ({run_vld, ovf} !== 2'b01) begin
      errors++;
      $display("FAIL ovf_sticky got vld/ovf=%b want=01", {run_vld, ovf});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_rdy = 1'b1;
    cyc(1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc(i[0]);
      checks++;
      if (obs !== {1'b1, ~i[0], 8'd1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL b2b_toggle i=%0d got=%h want=%h", i, obs, {1'b1, ~i[0], 8'd1, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_simul_xfer();
    do_reset();
    run_rdy = 1'b0;
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    checks++;
    if (obs !== {1'b1, 1'b1, 8'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL simul_hold got=%h want=%h", obs, {1'b1, 1'b1, 8'd3, 1'b0, 1'b0});
    end
    run_rdy = 1'b1;
    cyc(1'b1);
    checks++;
    if (obs !== {1'b1, 1'b0, 8'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL simul_replace got=%h want=%h", obs, {1'b1, 1'b0, 8'd2, 1'b0, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_reset();
    run_rdy = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 4; i++) cyc(1'b1);
    rst = 1'b0;
    cyc(1'b0);
    rst = 1'b1;
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL midrst_clear got=%h want=%h", obs, 12'h000);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      if (run_vld) pulses++;
    end
    cyc(1'b0);
    checks++;
    if (obs !== {1'b1, 1'b1, 8'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_result got=%h want=%h", obs, {1'b1, 1'b1, 8'd3, 1'b0, 1'b0});
    end
    if (run_vld) pulses++;
    cyc(1'b0);
    if (run_vld) pulses++;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL midrst_count got=%0d want=1", pulses);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b0;
    y       = 1'b0;
    run_rdy = 1'b0;
    test_reset();
    test_basic_run();
    test_saturation();
    test_overflow();
    test_back_to_back();
    test_simul_xfer();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_y_run_meter

// File: doc/y_run_meter.md
# y_run_meter

Run-length meter that sits directly downstream of the Moore sequence FSMs and consumes their single-bit output `y`. It measures each maximal run of constant `y`, giving its level and its length in clock cycles. Each completed run is presented as one result on a valid/ready output port. Results feed the FSM checker and trace logic.

## Interface

Parameters:
- `CW`, 8: width of the run-length counter and of `run_len`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `y`  in  1  monitored FSM output; sampled every cycle.
- `run_vld`  out  1  result valid.
- `run_rdy`  in  1  consumer ready; a transfer occurs on a cycle where `run_vld && run_rdy`.
- `run_lvl`  out  1  level of the reported run.
- `run_len`  out  CW  length of the reported run in cycles, saturating.
- `run_sat`  out  1  reported run reached the saturation value 2^CW-1.
- `ovf`  out  1  sticky; set when a completed run was dropped.

## Operation

- Reset (`rst`=0 at an edge):
  - State goes to SYNC.
  - `run_vld`, `run_lvl`, `run_len`, `run_sat` and `ovf` all go to 0.
  - The internal counter and level register are cleared.
  - Any pending result or partial run is discarded.
- FSM states:
  - SYNC → RUN on the first edge with `rst`=1. At that edge: `lvl`←`y`, `cnt`←1.
  - RUN, `y`==`lvl`: `cnt`←`cnt`+1, saturating at 2^CW-1.
  - RUN, `y`!=`lvl`: the run ends.
    - A result {`lvl`, `cnt`, `cnt`==2^CW-1} is offered to the output register.
    - A new run starts: `lvl`←`y`, `cnt`←1.
    - The state stays RUN.
- Output register, evaluated on each run-end edge:
  - Register empty, or transfer this cycle: load the result; `run_vld`←1.
  - Otherwise: drop the result, set `ovf`←1, and leave the held result unchanged.
- Output register, edges with no run end: on a transfer, `run_vld`←0.
- Output stability: `run_lvl`, `run_len` and `run_sat` hold their values while `run_vld`=1 and `run_rdy`=0.
- `ovf`: cleared only by reset.
- Saturation:
  - The counter never wraps.
  - Once it reaches 2^CW-1 it holds until the run ends.
  - A run of exactly 2^CW-1 cycles also reports `run_sat`=1.
- First run after reset: its length counts from the first sampled cycle after reset release, not from the true start of the level.

## Timing

- Latency: the first edge sampling the new `y` level ends the run. The result is visible on `run_vld` from that edge, i.e. one cycle after `y` changes at the input.
- Throughput: one result per cycle is sustained while `run_rdy`=1. For example, `y` toggling every cycle produces back-to-back results with `run_len`=1.
- Simultaneous transfer and run end: the new result replaces the old one in the same edge, `run_vld` stays 1, and `ovf` is unaffected.
- No combinational path from `run_rdy` or `y` to any output; all outputs are registered.
- Reset wins over every other event at the same edge.

## Structure

- Shared package `fsm_pkg`:
  - state encoding localparams: SYNC=1'b0, RUN=1'b1;
  - default `CW`.
- One sub-module, `sat_counter`:
  - parameter CW;
  - ports: `clk`, `rst`, `clr`, `inc`, `cnt`, `max`;
  - loads 1 on `clr`, otherwise increments on `inc` and saturates at 2^CW-1.
- The top module holds the FSM, the level register and the output register.

## Test plan

All scenarios use CW=8.

1. Reset: `rst`=0 for 3 cycles with `y` toggling → all outputs 0 throughout, including `ovf`.
2. Basic run: after reset release, `y`=0 for 5 sampled cycles, then 1; `run_rdy`=1 → `run_vld`=1 for exactly one cycle, after the first `y`=1 edge, with `run_lvl`=0, `run_len`=5, `run_sat`=0.
3. Saturation: `y`=1 for 300 cycles, then 0 → `run_len`=255, `run_sat`=1, `run_lvl`=1.
4. Overflow: `run_rdy`=0; `y` sequence 0,0,1,0,1 after reset →
   - first result (lvl 0, len 2) is held;
   - the later run ends are dropped and `ovf`=1;
   - the held result is unchanged;
   - asserting `run_rdy` for one cycle drains it, then `run_vld`=0.
5. Simultaneous transfer and run end: `run_vld`=1 holding (lvl 1, len 3) while `run_rdy`=1 and a run of (lvl 0, len 2) ends on the same edge → next cycle `run_vld`=1 with lvl 0, len 2, and `ovf`=0.
6. Reset mid-operation: `y`=1 for 4 cycles, `rst`=0 for 1 cycle, `y`=1 for 3 more cycles, then 0 → exactly one result, with `run_lvl`=1 and `run_len`=3.
